dice_roller_multi: RTL and testbench

- Parametrised multi-die roller for the electronic craps game.
- Runs NUM_DICE free-running face counters, chained odometer-style, off an internal divided tick; a player request starts a fixed-length tumble, then latches and reports the result.
- Outputs: live faces for display animation, latched faces, their sum and a doubles flag, consumed by game-rule logic; also a divided clock for display scanning.

---
 rtl/dice_roller_multi.sv | 252 +++++++++++++++++++++++++
 tb/tb_dice_roller_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller_multi.sv
// -----------------------------------------------------------------------------
// dice_roller_multi
//
// Multi-die roller for the electronic craps game. NUM_DICE face counters run
// continuously off a divided tick and are chained like an odometer: die0 steps
// on every tick, and each higher die steps only when every die below it sits on
// FACES. A rising edge on roll_req starts a tumble of ROLL_TICKS ticks. On the
// last tick the live faces (before that tick's advance) are latched, summed and
// reported.
//
// Ports
//   clk_in        system clock
//   reset         asynchronous, active-high reset
//   enable        low freezes divider, dice and FSM (done still clears)
//   roll_req      player request; a rising edge starts a roll
//   clk_out       divided clock, toggles on every tick
//   dice_live     live counter faces, die0 in the LSBs
//   dice_out      latched result faces, die0 in the LSBs
//   sum           arithmetic sum of the latched faces
//   doubles       result_valid and all latched faces equal
//   result_valid  a result has been latched since reset
//   busy          roll in progress
//   done          one-cycle pulse when a result is latched
// -----------------------------------------------------------------------------
module dice_roller_multi #(
  parameter int DIV        = 500,
  parameter int NUM_DICE   = 2,
  parameter int FACES      = 6,
  parameter int FACE_W     = 3,
  parameter int SUM_W      = 4,
  parameter int ROLL_TICKS = 16,
  parameter int CNT_W      = 9
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       roll_req,
  output logic                       clk_out,
  output logic [NUM_DICE*FACE_W-1:0] dice_live,
  output logic [NUM_DICE*FACE_W-1:0] dice_out,
  output logic [SUM_W-1:0]           sum,
  output logic                       doubles,
  output logic                       result_valid,
  output logic                       busy,
  output logic                       done
);

  // Tumble counter only needs to reach ROLL_TICKS-1.
  localparam int TC_W = (ROLL_TICKS > 1) ? $clog2(ROLL_TICKS) : 1;

  localparam logic [CNT_W-1:0]  DIV_C    = CNT_W'(DIV);
  localparam logic [FACE_W-1:0] FACE_MAX = FACE_W'(FACES);
  localparam logic [FACE_W-1:0] FACE_MIN = FACE_W'(1);
  localparam logic [TC_W-1:0]   TC_LAST  = TC_W'(ROLL_TICKS - 1);
  localparam logic [SUM_W-1:0]  SUM_RST  = SUM_W'(NUM_DICE);

  typedef enum logic {
    IDLE,
    ROLLING
  } state_t;

  // ---------------------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_reg;
  logic             clk_out_reg;
  logic             tick;

  // tick already carries enable, so everything gated by tick freezes with it.
  assign tick = enable && (count_reg == DIV_C);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_reg   <= '0;
      clk_out_reg <= 1'b0;
    end else if (tick) begin
      count_reg   <= '0;
      clk_out_reg <= ~clk_out_reg;
    end else if (enable && (count_reg < DIV_C)) begin
      count_reg   <= count_reg + CNT_W'(1);
    end
  end

  assign clk_out = clk_out_reg;

  // ---------------------------------------------------------------------------
  // Odometer-chained face counters
  // ---------------------------------------------------------------------------
  logic [FACE_W-1:0]   face_reg [NUM_DICE];
  logic [NUM_DICE-1:0] step_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DICE; gi++) begin : g_die
      // A die steps on the tick only if every lower die is at FACES, which
      // makes the whole bank wrap from all-FACES to all-1 in one tick.
      if (gi == 0) begin : g_first
        assign step_en[gi] = tick;
      end else begin : g_chain
        assign step_en[gi] = step_en[gi-1] && (face_reg[gi-1] == FACE_MAX);
      end

      always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
          face_reg[gi] <= FACE_MIN;
        end else if (step_en[gi]) begin
          if (face_reg[gi] == FACE_MAX) begin
            face_reg[gi] <= FACE_MIN;
          end else begin
            face_reg[gi] <= face_reg[gi] + FACE_W'(1);
          end
        end
      end

      assign dice_live[gi*FACE_W +: FACE_W] = face_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Request edge detection
  // ---------------------------------------------------------------------------
  logic roll_req_q;
  logic req_edge;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      roll_req_q <= 1'b0;
    end else if (enable) begin
      roll_req_q <= roll_req;
    end
  end

  // While frozen the history does not move, so no edge may be taken either.
  assign req_edge = enable && roll_req && !roll_req_q;

  // ---------------------------------------------------------------------------
  // Roll FSM
  // ---------------------------------------------------------------------------
  state_t          state_reg;
  state_t          state_next;
  logic [TC_W-1:0] tumble_reg;
  logic [TC_W-1:0] tumble_next;
  logic            latch_fire;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      tumble_reg <= '0;
    end else begin
      state_reg  <= state_next;
      tumble_reg <= tumble_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    tumble_next = tumble_reg;
    latch_fire  = 1'b0;
    case (state_reg)
      IDLE: begin
        // A tick coinciding with the accepting edge is deliberately not
        // counted: the tumble count starts from zero in ROLLING.
        if (req_edge) begin
          state_next  = ROLLING;
          tumble_next = '0;
        end
      end
      ROLLING: begin
        if (tick) begin
          if (tumble_reg == TC_LAST) begin
            latch_fire  = 1'b1;
            state_next  = IDLE;
            tumble_next = '0;
          end else begin
            tumble_next = tumble_reg + TC_W'(1);
          end
        end
      end
      default: begin
        state_next  = IDLE;
        tumble_next = '0;
      end
    endcase
  end

  assign busy = (state_reg == ROLLING);

  // ---------------------------------------------------------------------------
  // Result latch
  // ---------------------------------------------------------------------------
  logic [FACE_W-1:0] out_reg [NUM_DICE];
  logic [SUM_W-1:0]  live_sum;
  logic [SUM_W-1:0]  sum_reg;
  logic              result_valid_reg;
  logic              done_reg;

  // Sum of the faces as they stand before the current tick's advance.
  always_comb begin
    live_sum = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      live_sum = live_sum + SUM_W'(face_reg[i]);
    end
  end

  generate
    for (gi = 0; gi < NUM_DICE; gi++) begin : g_out
      always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
          out_reg[gi] <= FACE_MIN;
        end else if (latch_fire) begin
          out_reg[gi] <= face_reg[gi];
        end
      end

      assign dice_out[gi*FACE_W +: FACE_W] = out_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sum_reg          <= SUM_RST;
      result_valid_reg <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      // latch_fire requires a tick, hence enable; done therefore also clears
      // while the block is frozen.
      done_reg <= latch_fire;
      if (latch_fire) begin
        sum_reg          <= live_sum;
        result_valid_reg <= 1'b1;
      end
    end
  end

  assign sum          = sum_reg;
  assign result_valid = result_valid_reg;
  assign done         = done_reg;

  // ---------------------------------------------------------------------------
  // Doubles: every latched face matches die0
  // ---------------------------------------------------------------------------
  logic [NUM_DICE-1:0] match;

  generate
    for (gi = 0; gi < NUM_DICE; gi++) begin : g_match
      assign match[gi] = (out_reg[gi] == out_reg[0]);
    end
  endgenerate

  assign doubles = result_valid_reg && (&match);

endmodule

// File: tb/tb_dice_roller_multi.sv
// -----------------------------------------------------------------------------
// tb_dice_roller_multi
//
// Directed bench for dice_roller_multi with DIV=3 (tick every 4 cycles),
// two six-sided dice and ROLL_TICKS=4. Time is counted in falling edges after
// reset release (cycle n = the falling edge after rising edge n); inputs are
// driven and outputs sampled on falling edges. Tick k lands on rising edge 4k,
// and after k ticks the live faces are die0 = k%6+1, die1 = (k/6)%6+1.
// -----------------------------------------------------------------------------
module tb_dice_roller_multi;

  localparam int DIV        = 3;
  localparam int NUM_DICE   = 2;
  localparam int FACES      = 6;
  localparam int FACE_W     = 3;
  localparam int SUM_W      = 4;
  localparam int ROLL_TICKS = 4;
  localparam int CNT_W      = 2;

  logic                       clk_in;
  logic                       reset;
  logic                       enable;
  logic                       roll_req;
  logic                       clk_out;
  logic [NUM_DICE*FACE_W-1:0] dice_live;
  logic [NUM_DICE*FACE_W-1:0] dice_out;
  logic [SUM_W-1:0]           sum;
  logic                       doubles;
  logic                       result_valid;
  logic                       busy;
  logic                       done;

  int tests_run;
  int tests_failed;
  int cyc;
  int done_cnt;

  dice_roller_multi #(
    .DIV        (DIV),
    .NUM_DICE   (NUM_DICE),
    .FACES      (FACES),
    .FACE_W     (FACE_W),
    .SUM_W      (SUM_W),
    .ROLL_TICKS (ROLL_TICKS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .enable       (enable),
    .roll_req     (roll_req),
    .clk_out      (clk_out),
    .dice_live    (dice_live),
    .dice_out     (dice_out),
    .sum          (sum),
    .doubles      (doubles),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (done === 1'b1) done_cnt++;
  end

  // Pack two faces as {die1, die0}.
  function automatic logic [5:0] faces(input int d1, input int d0);
    return {3'(d1), 3'(d0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(negedge clk_in);
      cyc++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_clk_out"}, 32'(clk_out), 32'd0);
    check({tag, "_live"}, 32'(dice_live), 32'(faces(1, 1)));
    check({tag, "_out"}, 32'(dice_out), 32'(faces(1, 1)));
    check({tag, "_sum"}, 32'(sum), 32'd2);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_doubles"}, 32'(doubles), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic report_roll(input int idx);
    $display("[TB] roll %0d: dice_out die0=%0d die1=%0d sum=%0d doubles=%0d",
             idx, dice_out[2:0], dice_out[5:3], sum, doubles);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    done_cnt     = 0;
    cyc          = 0;
    reset        = 1'b1;
    enable       = 1'b1;
    roll_req     = 1'b0;

    repeat (3) @(negedge clk_in);
    check_reset_values("rst");
    reset = 1'b0;
    cyc   = 0;

    // Roll 1: request pulse before the first tick; latches on tick 4.
    to_cycle(1);
    check("r1_busy_before", 32'(busy), 32'd0);
    roll_req = 1'b1;
    to_cycle(2);
    roll_req = 1'b0;
    check("r1_busy", 32'(busy), 32'd1);
    to_cycle(3);
    check("clk_out_c3", 32'(clk_out), 32'd0);
    to_cycle(4);
    check("clk_out_c4", 32'(clk_out), 32'd1);
    check("live_t1", 32'(dice_live), 32'(faces(1, 2)));
    to_cycle(8);
    check("clk_out_c8", 32'(clk_out), 32'd0);
    to_cycle(15);
    check("r1_done_early", 32'(done), 32'd0);
    check("r1_valid_early", 32'(result_valid), 32'd0);
    to_cycle(16);
    check("r1_done", 32'(done), 32'd1);
    check("r1_out", 32'(dice_out), 32'(faces(1, 4)));
    check("r1_sum", 32'(sum), 32'd5);
    check("r1_doubles", 32'(doubles), 32'd0);
    check("r1_valid", 32'(result_valid), 32'd1);
    check("r1_busy_after", 32'(busy), 32'd0);
    check("r1_live", 32'(dice_live), 32'(faces(1, 5)));
    report_roll(1);
    to_cycle(17);
    check("r1_done_pulse", 32'(done), 32'd0);

    // Odometer carry and full 36-tick cycle.
    to_cycle(20);
    check("live_t5", 32'(dice_live), 32'(faces(1, 6)));
    to_cycle(23);
    check("live_t5_hold", 32'(dice_live), 32'(faces(1, 6)));
    to_cycle(24);
    check("live_t6", 32'(dice_live), 32'(faces(2, 1)));
    to_cycle(140);
    check("live_t35", 32'(dice_live), 32'(faces(6, 6)));
    to_cycle(144);
    check("live_t36", 32'(dice_live), 32'(faces(1, 1)));

    // Roll 2: edge during ROLLING ignored, held-high request never retriggers.
    to_cycle(150);
    roll_req = 1'b1;
    to_cycle(152);
    roll_req = 1'b0;
    check("r2_busy", 32'(busy), 32'd1);
    to_cycle(154);
    roll_req = 1'b1;
    to_cycle(163);
    check("r2_done_early", 32'(done), 32'd0);
    to_cycle(164);
    check("r2_done", 32'(done), 32'd1);
    check("r2_out", 32'(dice_out), 32'(faces(1, 5)));
    check("r2_sum", 32'(sum), 32'd6);
    check("r2_doubles", 32'(doubles), 32'd0);
    report_roll(2);
    to_cycle(180);
    check("r2_held_busy", 32'(busy), 32'd0);
    to_cycle(182);
    check("r2_done_count", 32'(done_cnt), 32'd2);
    roll_req = 1'b0;

    // Roll 3: lands on (3,3).
    to_cycle(189);
    roll_req = 1'b1;
    to_cycle(190);
    roll_req = 1'b0;
    check("r3_busy", 32'(busy), 32'd1);
    to_cycle(204);
    check("r3_done", 32'(done), 32'd1);
    check("r3_out", 32'(dice_out), 32'(faces(3, 3)));
    check("r3_sum", 32'(sum), 32'd6);
    check("r3_doubles", 32'(doubles), 32'd1);
    report_roll(3);

    // Roll 4: 10-cycle freeze mid-roll pushes the latch from cycle 220 to 230.
    to_cycle(206);
    roll_req = 1'b1;
    to_cycle(207);
    roll_req = 1'b0;
    to_cycle(209);
    enable = 1'b0;
    to_cycle(215);
    check("frz_live", 32'(dice_live), 32'(faces(3, 5)));
    check("frz_clk_out", 32'(clk_out), 32'd0);
    check("frz_busy", 32'(busy), 32'd1);
    to_cycle(219);
    check("frz_live_end", 32'(dice_live), 32'(faces(3, 5)));
    enable = 1'b1;
    to_cycle(220);
    check("r4_no_done_nominal", 32'(done), 32'd0);
    to_cycle(222);
    check("r4_tick_shifted", 32'(dice_live), 32'(faces(3, 6)));
    check("r4_clk_out", 32'(clk_out), 32'd1);
    to_cycle(229);
    check("r4_done_early", 32'(done), 32'd0);
    to_cycle(230);
    check("r4_done", 32'(done), 32'd1);
    check("r4_out", 32'(dice_out), 32'(faces(4, 1)));
    check("r4_sum", 32'(sum), 32'd5);
    check("r4_doubles", 32'(doubles), 32'd0);
    report_roll(4);

    // Roll 5: asynchronous reset mid-roll.
    to_cycle(232);
    roll_req = 1'b1;
    to_cycle(233);
    roll_req = 1'b0;
    to_cycle(240);
    check("r5_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("arst");
    to_cycle(250);
    check_reset_values("arst_hold");
    check("final_done_count", 32'(done_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
